cache_sram: RTL and testbench
=============================

// Module: cache_sram
// PURPOSE
//  Simple dual-port (1W/1R) synchronous SRAM model for the cache data/tag arrays.
//  Supports per-byte write enables, a read-valid qualifier and 1- or 2-cycle read latency.
//  Same-address read/write collisions use write-first forwarding.
//  After reset, a hardware init sequencer zeroes every entry before accepting traffic.
// PARAMETERS
//  ADDR_WIDTH    10  address bits; depth DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH    64  word width; must be a multiple of 8 (NB = DATA_WIDTH/8 byte lanes)
//  READ_LATENCY  1   cycles from rd_en to rd_valid; legal values 1 or 2 (elaboration error otherwise)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  init_busy  out  1           high while the init sequencer clears the array
//  wr_en      in   1           write request
//  wr_addr    in   ADDR_WIDTH  write address
//  wr_data    in   DATA_WIDTH  write data
//  wr_be      in   NB          byte enables; bit i controls wr_data[8i+7:8i]
//  rd_en      in   1           read request
//  rd_addr    in   ADDR_WIDTH  read address
//  rd_data    out  DATA_WIDTH  read data; qualified by rd_valid
//  rd_valid   out  1           rd_data valid this cycle
//  parity_err out  1           read parity mismatch; qualified by rd_valid (tied 0 without macro)
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - rd_data=0, rd_valid=0, parity_err=0; all pipeline/valid regs cleared.
//    - init_busy=1; FSM enters CLEAR with counter=0.
//    - Array contents are not async-reset.
//  - FSM CLEAR:
//    - Each clock: mem[counter] <= 0 (all bytes, and parity if enabled); counter++.
//    - On the edge that writes DEPTH-1, go to READY; no counter wrap is used.
//    - init_busy deasserts after exactly DEPTH edges following rst_n release.
//    - wr_en and rd_en are ignored; rd_valid stays 0.
//  - FSM READY: no exit except reset.
//  - Write (READY, wr_en=1):
//    - Each byte i with wr_be[i]=1 updates mem[wr_addr][i]; other bytes hold.
//    - wr_be=0 is a no-op.
//  - Read (READY, rd_en=1 at edge N):
//    - rd_valid=1 and rd_data valid after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request.
//    - Full throughput: one read per cycle; rd_valid is a 1-cycle pulse per request.
//    - rd_data holds its last value while rd_valid=0.
//  - Collision (rd_en & wr_en, rd_addr==wr_addr, same cycle):
//    - Returned word = old word with the enabled bytes replaced by wr_data (write-first).
//    - Write to A then read A the next cycle returns the new data.
//  - READ_LATENCY=2: stage 1 is the array read (with forwarding); stage 2 is a plain output register for data, valid and parity_err.
//  - Reset mid-operation: in-flight reads are dropped (rd_valid never pulses) and CLEAR restarts at address 0.
// CONFIGURATION
//  CACHE_SRAM_PARITY_EN defined:
//    - Array stores NB extra even-parity bits, one per byte, computed from the merged written bytes.
//    - CLEAR writes parity 0.
//    - On read, parity is recomputed per byte; parity_err=1 with rd_valid if any byte mismatches.
//    - Forwarded collision data uses freshly computed parity (no error).
//  CACHE_SRAM_PARITY_EN undefined:
//    - No parity storage; parity_err is constant 0.
//    - Data behaviour is identical in both configurations.
// TESTING (defaults unless stated)
//  1 Release rst_n -> init_busy=1 for exactly 1024 cycles; then rd 0x3FF -> rd_valid next cycle, rd_data=0.
//  2 wr 5 data 0x1122334455667788 be 0xFF; wr 5 data 0xAAAAAAAAAAAAAAAA be 0x0F; rd 5 -> 0x11223344AAAAAAAA.
//  3 Addr 7 = 0; same cycle wr 7 data all-ones be 0x01 and rd 7 -> 0x00000000000000FF; rd 7 again -> same.
//  4 READ_LATENCY=2: rd 1,2,3 back-to-back -> rd_valid high 3 consecutive cycles starting 2 cycles after first rd_en, data in order.
//  5 rd_en at cycle N, rst_n low at N+1 -> rd_valid never asserts; init_busy=1; rd during CLEAR -> no rd_valid.
//  6 Macro on: wr 9 any data; flip mem[9] bit 0 hierarchically; rd 9 -> rd_valid=1, parity_err=1; macro off -> parity_err=0.

Source files
------------

// File: rtl/cache_sram_if.sv
// Bus bundle for cache_sram: write port, read port, read status and init status.
// The master drives requests; the slave (the SRAM) returns read data and status.
interface cache_sram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  init_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  parity_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, parity_err, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, parity_err, init_busy
  );
endinterface

// File: rtl/cache_sram.sv
// 1W/1R synchronous SRAM with byte enables, write-first forwarding, 1/2-cycle read
// latency and a post-reset clear sequencer. Optional per-byte parity: CACHE_SRAM_PARITY_EN.
module cache_sram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_sram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("cache_sram: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("cache_sram: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire, rd_fire, collide;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;

  logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  perr_p1_q, perr_p1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = S_READY;
      else                             cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.init_busy = (state_q == S_CLEAR);
  assign wr_fire = (state_q == S_READY) && bus.wr_en;
  assign rd_fire = (state_q == S_READY) && bus.rd_en;
  assign collide = wr_fire && (bus.rd_addr == bus.wr_addr);

  // Merged write word: old contents with enabled bytes replaced; also the forwarded read value.
  always_comb begin
    wr_word = mem[bus.wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) wr_word[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  assign rd_word = mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) mem[cnt_q]       <= '0;
    else if (wr_fire)       mem[bus.wr_addr] <= wr_word;
  end

`ifdef CACHE_SRAM_PARITY_EN
  logic [NB-1:0] mem_par [DEPTH];

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) mem_par[cnt_q]       <= '0;
    else if (wr_fire)       mem_par[bus.wr_addr] <= byte_parity(wr_word);
  end
`endif

  // Stage 1: array read with write-first forwarding.
  always_comb begin
    vld_p1_d     = rd_fire;
    rd_data_p1_d = rd_data_p1_q;
    perr_p1_d    = 1'b0;
    if (rd_fire) begin
      if (collide) begin
        rd_data_p1_d = wr_word;
      end else begin
        rd_data_p1_d = rd_word;
`ifdef CACHE_SRAM_PARITY_EN
        perr_p1_d    = |(mem_par[bus.rd_addr] ^ byte_parity(rd_word));
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      rd_data_p1_q <= '0;
      perr_p1_q    <= 1'b0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      rd_data_p1_q <= rd_data_p1_d;
      perr_p1_q    <= perr_p1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;
    logic                  vld_p2_q, vld_p2_d;
    logic                  perr_p2_q, perr_p2_d;

    // Stage 2: plain output register, data held while nothing new arrives.
    always_comb begin
      vld_p2_d     = vld_p1_q;
      perr_p2_d    = perr_p1_q;
      rd_data_p2_d = vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q     <= 1'b0;
        rd_data_p2_q <= '0;
        perr_p2_q    <= 1'b0;
      end else begin
        vld_p2_q     <= vld_p2_d;
        rd_data_p2_q <= rd_data_p2_d;
        perr_p2_q    <= perr_p2_d;
      end
    end

    assign bus.rd_valid   = vld_p2_q;
    assign bus.rd_data    = rd_data_p2_q;
    assign bus.parity_err = perr_p2_q;
  end else begin : g_lat1
    assign bus.rd_valid   = vld_p1_q;
    assign bus.rd_data    = rd_data_p1_q;
    assign bus.parity_err = perr_p1_q;
  end
endmodule

// File: tb/tb_cache_sram.sv
// Directed bench for cache_sram: one READ_LATENCY=1 instance and one READ_LATENCY=2
// instance sharing clock and reset.
module tb_cache_sram;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;
  logic saw_vld;

  cache_sram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) bus1 ();
  cache_sram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) bus2 ();

  cache_sram #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  cache_sram #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_be = '0;
    bus1.rd_en = 1'b0; bus1.rd_addr = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_be = '0;
    bus2.rd_en = 1'b0; bus2.rd_addr = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", bus1.init_busy, 1);
    chk("rst_vld", bus1.rd_valid, 0);
    chk("rst_data", bus1.rd_data, 0);
    chk("rst_perr", bus1.parity_err, 0);
    chk("rst_vld2", bus2.rd_valid, 0);

    // Clear sequence lasts exactly DEPTH edges
    rst_n = 1'b1;
    n = 0;
    while (bus1.init_busy && n < 1100) begin
      tick();
      n++;
    end
    chk("init_cycles", n, 1024);
    chk("init_busy2", bus2.init_busy, 0);

    bus1.rd_en = 1'b1; bus1.rd_addr = 10'h3FF;
    tick();
    bus1.rd_en = 1'b0;
    chk("rd3ff_vld", bus1.rd_valid, 1);
    chk("rd3ff_data", bus1.rd_data, 0);
    tick();
    chk("rd_pulse", bus1.rd_valid, 0);

    // Byte-enable merge
    bus1.wr_en = 1'b1; bus1.wr_addr = 10'd5; bus1.wr_data = 64'h1122334455667788; bus1.wr_be = 8'hFF;
    tick();
    bus1.wr_data = 64'hAAAAAAAAAAAAAAAA; bus1.wr_be = 8'h0F;
    tick();
    bus1.wr_en = 1'b0;
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd5;
    tick();
    bus1.rd_en = 1'b0;
    chk("be_merge", bus1.rd_data, 64'h11223344AAAAAAAA);

    // wr_be=0 leaves the word untouched
    bus1.wr_en = 1'b1; bus1.wr_addr = 10'd5; bus1.wr_data = 64'h0; bus1.wr_be = 8'h00;
    tick();
    bus1.wr_en = 1'b0;
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd5;
    tick();
    bus1.rd_en = 1'b0;
    chk("be_zero", bus1.rd_data, 64'h11223344AAAAAAAA);

    // Same-cycle collision returns write-first data
    bus1.wr_en = 1'b1; bus1.wr_addr = 10'd7; bus1.wr_data = '1; bus1.wr_be = 8'h01;
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd7;
    tick();
    bus1.wr_en = 1'b0;
    chk("coll_vld", bus1.rd_valid, 1);
    chk("coll_data", bus1.rd_data, 64'h00000000000000FF);
    chk("coll_perr", bus1.parity_err, 0);
    tick();
    bus1.rd_en = 1'b0;
    chk("coll_again", bus1.rd_data, 64'h00000000000000FF);
    tick();
    chk("hold_vld", bus1.rd_valid, 0);
    chk("hold_data", bus1.rd_data, 64'h00000000000000FF);

    // Latency-2 back-to-back reads
    for (int i = 1; i <= 3; i++) begin
      bus2.wr_en = 1'b1; bus2.wr_addr = 10'(i); bus2.wr_data = 64'hC0DE_0000_0000_0000 | 64'(i); bus2.wr_be = 8'hFF;
      tick();
    end
    bus2.wr_en = 1'b0;
    bus2.rd_en = 1'b1; bus2.rd_addr = 10'd1;
    tick();
    chk("l2_first_edge", bus2.rd_valid, 0);
    bus2.rd_addr = 10'd2;
    tick();
    chk("l2_vld1", bus2.rd_valid, 1);
    chk("l2_data1", bus2.rd_data, 64'hC0DE_0000_0000_0001);
    bus2.rd_addr = 10'd3;
    tick();
    bus2.rd_en = 1'b0;
    chk("l2_vld2", bus2.rd_valid, 1);
    chk("l2_data2", bus2.rd_data, 64'hC0DE_0000_0000_0002);
    tick();
    chk("l2_vld3", bus2.rd_valid, 1);
    chk("l2_data3", bus2.rd_data, 64'hC0DE_0000_0000_0003);
    tick();
    chk("l2_done", bus2.rd_valid, 0);

    // Parity error detection
    bus1.wr_en = 1'b1; bus1.wr_addr = 10'd9; bus1.wr_data = 64'h0123456789ABCDEF; bus1.wr_be = 8'hFF;
    tick();
    bus1.wr_en = 1'b0;
`ifdef CACHE_SRAM_PARITY_EN
    dut1.mem[9][0] = ~dut1.mem[9][0];
`endif
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd9;
    tick();
    bus1.rd_en = 1'b0;
    chk("par_vld", bus1.rd_valid, 1);
`ifdef CACHE_SRAM_PARITY_EN
    chk("par_err", bus1.parity_err, 1);
`else
    chk("par_err", bus1.parity_err, 0);
    chk("par_data", bus1.rd_data, 64'h0123456789ABCDEF);
`endif

    // Reset while a latency-2 read is in flight
    bus2.rd_en = 1'b1; bus2.rd_addr = 10'd1;
    tick();
    bus2.rd_en = 1'b0;
    chk("mid_pre_vld", bus2.rd_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", bus2.init_busy, 1);
    chk("mid_data", bus2.rd_data, 0);
    tick();
    chk("mid_vld", bus2.rd_valid, 0);
    rst_n = 1'b1;
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd5;
    bus1.wr_en = 1'b1; bus1.wr_addr = 10'd5; bus1.wr_data = '1; bus1.wr_be = 8'hFF;
    saw_vld = 1'b0;
    n = 0;
    while (bus1.init_busy && n < 1100) begin
      tick();
      n++;
      if (bus1.rd_valid || bus2.rd_valid) saw_vld = 1'b1;
    end
    bus1.rd_en = 1'b0;
    bus1.wr_en = 1'b0;
    chk("clr_no_vld", saw_vld, 0);
    chk("reinit_cycles", n, 1024);
    bus1.rd_en = 1'b1; bus1.rd_addr = 10'd5;
    tick();
    bus1.rd_en = 1'b0;
    chk("reclear_vld", bus1.rd_valid, 1);
    chk("reclear_data", bus1.rd_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
